// File: rtl/service_4_alarm_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// service_4_alarm_sequencer_pkg
// Shared definitions for the alarm-service sequencer: FSM state codes, bus
// widths and the helper that turns the random generator output into a
// game target.
// -----------------------------------------------------------------------------
package service_4_alarm_sequencer_pkg;

  localparam int TIME_W   = 16;  // HH:MM in BCD-ish packed form
  localparam int TARGET_W = 10;  // one LED / slide switch per bit

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ARMED  = 3'd1;
  localparam logic [2:0] ST_RING   = 3'd2;
  localparam logic [2:0] ST_GAME   = 3'd3;
  localparam logic [2:0] ST_CLEAR  = 3'd4;
  localparam logic [2:0] ST_SNOOZE = 3'd5;

  // The random source is not guaranteed to be one-hot; anything else falls
  // back to the lowest LED so the player always has exactly one target.
  function automatic logic [TARGET_W-1:0] latch_target(input logic [TARGET_W-1:0] hot);
    logic [3:0] ones;
    ones = 4'd0;
    for (int i = 0; i < TARGET_W; i++) begin
      ones = ones + {3'b000, hot[i]};
    end
    return (ones == 4'd1) ? hot : {{(TARGET_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/service_4_alarm_sequencer_if.sv
// -----------------------------------------------------------------------------
// service_4_alarm_sequencer_if
// Bundles the sequencer's functional I/O.
//   master : the surrounding system (time core, random generator, switches,
//            button) driving inputs and observing LED/buzzer/status outputs.
//   slave  : the sequencer itself.
// Signals:
//   tick, enable, current_time, alarm_time, push_m, rand_hot, spdts -> slave
//   state, buzzer, target_led, round_idx, snooze_cnt, time_left,
//   dismissed                                                       <- slave
// -----------------------------------------------------------------------------
interface service_4_alarm_sequencer_if
  import service_4_alarm_sequencer_pkg::*;
#(
  parameter int TW = 9
);
  logic                tick;
  logic                enable;
  logic [TIME_W-1:0]   current_time;
  logic [TIME_W-1:0]   alarm_time;
  logic                push_m;
  logic [TARGET_W-1:0] rand_hot;
  logic [TARGET_W-1:0] spdts;

  logic [2:0]          state;
  logic                buzzer;
  logic [TARGET_W-1:0] target_led;
  logic [1:0]          round_idx;
  logic [1:0]          snooze_cnt;
  logic [TW-1:0]       time_left;
  logic                dismissed;

  modport master (
    output tick, enable, current_time, alarm_time, push_m, rand_hot, spdts,
    input  state, buzzer, target_led, round_idx, snooze_cnt, time_left, dismissed
  );

  modport slave (
    input  tick, enable, current_time, alarm_time, push_m, rand_hot, spdts,
    output state, buzzer, target_led, round_idx, snooze_cnt, time_left, dismissed
  );
endinterface

// File: rtl/service_4_tick_timer.sv
// -----------------------------------------------------------------------------
// service_4_tick_timer
// TW-bit loadable down-counter stepped by the 1 Hz tick. Load beats tick,
// and the count saturates at zero.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   load         : load load_value this cycle
//   load_value   : value to load
//   tick         : decrement request
//   count        : current count
//   zero         : count == 0
// -----------------------------------------------------------------------------
module service_4_tick_timer #(
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  input  logic          tick,
  output logic [TW-1:0] count,
  output logic          zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && !zero) begin
      count <= count - TW'(1);
    end
  end

endmodule

// File: rtl/service_4_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// service_4_alarm_sequencer
// Alarm-service top: arms on the service switch, rings on the rising edge of
// the time match, runs a multi-round LED matching game to dismiss, and
// auto-snoozes a bounded number of times when the alarm goes unanswered.
// Ports:
//   clk     : system clock
//   resetn  : synchronous reset, HIGH = reset (legacy name)
//   bus     : slave side of service_4_alarm_sequencer_if (all functional I/O)
// All outputs are registered; state changes appear one cycle after the
// inputs that cause them.
// -----------------------------------------------------------------------------
module service_4_alarm_sequencer
  import service_4_alarm_sequencer_pkg::*;
#(
  parameter int ROUNDS       = 3,
  parameter int ROUND_TICKS  = 10,
  parameter int RING_TICKS   = 60,
  parameter int SNOOZE_TICKS = 300,
  parameter int MAX_SNOOZE   = 3,
  parameter int TW           = 9
) (
  input logic clk,
  input logic resetn,
  service_4_alarm_sequencer_if.slave bus
);

  localparam logic [TW-1:0] ROUND_LD  = TW'(ROUND_TICKS);
  localparam logic [TW-1:0] RING_LD   = TW'(RING_TICKS);
  localparam logic [TW-1:0] SNOOZE_LD = TW'(SNOOZE_TICKS);
  localparam logic [TW-1:0] ONE_LEFT  = TW'(1);
  localparam logic [1:0]    LAST_RND  = 2'(ROUNDS - 1);
  localparam logic [1:0]    SNZ_LIMIT = 2'(MAX_SNOOZE);

  logic [2:0]          state_q, state_d;
  logic [1:0]          round_q, round_d;
  logic [1:0]          snz_q, snz_d;
  logic [TARGET_W-1:0] target_q, target_d;
  logic                match, match_d;
  logic                trigger, expire;
  logic                dismissed_d;
  logic                buzzer_q, dismissed_q;
  logic [TARGET_W-1:0] led_q;

  logic                tmr_load, tmr_tick, tmr_zero;
  logic [TW-1:0]       tmr_value, tmr_count;

  service_4_tick_timer #(.TW(TW)) u_timer (
    .clk        (clk),
    .rst        (resetn),
    .load       (tmr_load),
    .load_value (tmr_value),
    .tick       (tmr_tick),
    .count      (tmr_count),
    .zero       (tmr_zero)
  );

  assign match   = (bus.current_time == bus.alarm_time);
  assign trigger = match & ~match_d;
  // Expiry is the tick that would take the timer from 1 to 0.
  assign expire  = bus.tick & (tmr_count == ONE_LEFT);

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    snz_d       = snz_q;
    target_d    = target_q;
    dismissed_d = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    tmr_tick    = 1'b0;

    if (!bus.enable) begin
      state_d  = ST_IDLE;
      round_d  = 2'd0;
      snz_d    = 2'd0;
      target_d = '0;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_ARMED;

        ST_ARMED: begin
          if (trigger) begin
            state_d   = ST_RING;
            snz_d     = 2'd0;
            tmr_load  = 1'b1;
            tmr_value = RING_LD;
          end
        end

        // RING and SNOOZE share the early-solve path: the button starts the game.
        ST_RING, ST_SNOOZE: begin
          if (bus.push_m) begin
            state_d   = ST_GAME;
            round_d   = 2'd0;
            target_d  = latch_target(bus.rand_hot);
            tmr_load  = 1'b1;
            tmr_value = ROUND_LD;
          end else if (state_q == ST_SNOOZE && expire) begin
            state_d   = ST_RING;
            tmr_load  = 1'b1;
            tmr_value = RING_LD;
          end else if (state_q == ST_RING && expire && snz_q < SNZ_LIMIT) begin
            state_d   = ST_SNOOZE;
            snz_d     = snz_q + 2'd1;
            tmr_load  = 1'b1;
            tmr_value = SNOOZE_LD;
          end else begin
            // With snoozes exhausted the timer runs down to 0 and parks there.
            tmr_tick = bus.tick & ~tmr_zero;
          end
        end

        ST_GAME: begin
          if (bus.spdts == target_q) begin
            if (round_q == LAST_RND) begin
              state_d     = ST_ARMED;
              dismissed_d = 1'b1;
              snz_d       = 2'd0;
              round_d     = 2'd0;
              tmr_load    = 1'b1;
            end else begin
              // The timer freezes from the winning cycle onward.
              state_d = ST_CLEAR;
            end
          end else if (expire) begin
            state_d   = ST_RING;
            round_d   = 2'd0;
            tmr_load  = 1'b1;
            tmr_value = RING_LD;
          end else begin
            tmr_tick = bus.tick;
          end
        end

        ST_CLEAR: begin
          if (bus.spdts == '0) begin
            state_d   = ST_GAME;
            round_d   = round_q + 2'd1;
            target_d  = latch_target(bus.rand_hot);
            tmr_load  = 1'b1;
            tmr_value = ROUND_LD;
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      round_q     <= 2'd0;
      snz_q       <= 2'd0;
      target_q    <= '0;
      match_d     <= 1'b0;
      buzzer_q    <= 1'b0;
      led_q       <= '0;
      dismissed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      snz_q       <= snz_d;
      target_q    <= target_d;
      match_d     <= bus.enable & match;
      // Outputs are registered from the next-state values so they line up
      // with the state register.
      buzzer_q    <= (state_d == ST_RING) || (state_d == ST_GAME) || (state_d == ST_CLEAR);
      led_q       <= (state_d == ST_GAME) ? target_d : '0;
      dismissed_q <= dismissed_d;
    end
  end

  assign bus.state      = state_q;
  assign bus.buzzer     = buzzer_q;
  assign bus.target_led = led_q;
  assign bus.round_idx  = round_q;
  assign bus.snooze_cnt = snz_q;
  assign bus.time_left  = tmr_count;
  assign bus.dismissed  = dismissed_q;

endmodule

// File: tb/tb_service_4_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_service_4_alarm_sequencer
// Directed vector table, hand-written corner sequences and a randomized run
// against a behavioural model of the alarm sequencer.
// -----------------------------------------------------------------------------
module tb_service_4_alarm_sequencer;

  localparam int TW = 9;
  localparam int N_ROUNDS = 3, T_ROUND = 4, T_RING = 5, T_SNOOZE = 3, N_SNOOZE = 2;

  localparam int S_IDLE = 0, S_ARMED = 1, S_RING = 2, S_GAME = 3, S_CLEAR = 4, S_SNOOZE = 5;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  service_4_alarm_sequencer_if #(.TW(TW)) bus ();

  service_4_alarm_sequencer #(
    .ROUNDS(N_ROUNDS), .ROUND_TICKS(T_ROUND), .RING_TICKS(T_RING),
    .SNOOZE_TICKS(T_SNOOZE), .MAX_SNOOZE(N_SNOOZE), .TW(TW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic [15:0] ct;
    logic        tk;
    logic        pm;
    logic [9:0]  rh;
    logic [9:0]  sw;
    logic [27:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [27:0] pack(input int st, input logic bz, input logic [9:0] led,
                                       input int rnd, input int snz, input int tl, input logic dis);
    return {3'(st), bz, led, 2'(rnd), 2'(snz), 9'(tl), dis};
  endfunction

  function automatic string fmt(input logic [27:0] v);
    return $sformatf("st=%0d bz=%0d led=%h rnd=%0d snz=%0d tl=%0d dis=%0d",
                     v[27:25], v[24], v[23:14], v[13:12], v[11:10], v[9:1], v[0]);
  endfunction

  function logic [27:0] actual();
    return {bus.state, bus.buzzer, bus.target_led, bus.round_idx, bus.snooze_cnt,
            bus.time_left, bus.dismissed};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %s, want %s", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, input logic [15:0] ct, input logic tk, input logic pm,
                     input logic [9:0] rh, input logic [9:0] sw, input int st, input logic bz,
                     input logic [9:0] led, input int rnd, input int snz, input int tl,
                     input logic dis);
    vec_t v;
    v.en = en; v.ct = ct; v.tk = tk; v.pm = pm; v.rh = rh; v.sw = sw;
    v.exp = pack(st, bz, led, rnd, snz, tl, dis);
    vecs.push_back(v);
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_mode, m_timer, m_round, m_snz;
  logic [9:0] m_target;
  bit         m_prev, m_dis;

  function automatic logic [9:0] pick(input logic [9:0] h);
    return ($countones(h) == 1) ? h : 10'h001;
  endfunction

  task automatic model_clear();
    m_mode = S_IDLE; m_timer = 0; m_round = 0; m_snz = 0;
    m_target = '0; m_prev = 0; m_dis = 0;
  endtask

  task automatic model_start_game();
    m_mode = S_GAME; m_round = 0; m_target = pick(bus.rand_hot); m_timer = T_ROUND;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step(input bit rst);
    bit match, trig, expire;
    match = (bus.current_time == bus.alarm_time);
    m_dis = 0;
    if (rst || !bus.enable) begin
      model_clear();
      return;
    end
    trig   = match && !m_prev;
    expire = bus.tick && (m_timer == 1);
    case (m_mode)
      S_IDLE: m_mode = S_ARMED;
      S_ARMED: if (trig) begin m_mode = S_RING; m_timer = T_RING; m_snz = 0; end
      S_RING: begin
        if (bus.push_m) model_start_game();
        else if (expire && m_snz < N_SNOOZE) begin
          m_mode = S_SNOOZE; m_snz++; m_timer = T_SNOOZE;
        end else if (bus.tick && m_timer > 0) m_timer--;
      end
      S_SNOOZE: begin
        if (bus.push_m) model_start_game();
        else if (expire) begin m_mode = S_RING; m_timer = T_RING; end
        else if (bus.tick && m_timer > 0) m_timer--;
      end
      S_GAME: begin
        if (bus.spdts == m_target) begin
          if (m_round == N_ROUNDS - 1) begin
            m_mode = S_ARMED; m_dis = 1; m_snz = 0; m_round = 0; m_timer = 0;
          end else m_mode = S_CLEAR;
        end else if (expire) begin
          m_mode = S_RING; m_timer = T_RING; m_round = 0;
        end else if (bus.tick) m_timer--;
      end
      S_CLEAR: begin
        if (bus.spdts == '0) begin
          m_round++; m_target = pick(bus.rand_hot); m_timer = T_ROUND; m_mode = S_GAME;
        end
      end
      default: m_mode = S_IDLE;
    endcase
    m_prev = match;
  endtask

  function automatic logic [27:0] model_exp();
    logic bz;
    bz = (m_mode == S_RING) || (m_mode == S_GAME) || (m_mode == S_CLEAR);
    return pack(m_mode, bz, (m_mode == S_GAME) ? m_target : 10'h000, m_round, m_snz,
                m_timer, m_dis);
  endfunction

  initial begin
    resetn           = 1'b1;
    bus.tick         = 1'b0;
    bus.enable       = 1'b0;
    bus.current_time = 16'h0659;
    bus.alarm_time   = 16'h0700;
    bus.push_m       = 1'b0;
    bus.rand_hot     = '0;
    bus.spdts        = '0;
    step();
    step();
    check("reset_state", actual(), pack(S_IDLE, 0, 0, 0, 0, 0, 0));
    resetn = 1'b0;

    // ---------------- directed vector table ----------------
    add(0, 16'h0659, 0, 0, 10'h0, 10'h0, S_IDLE,  0, 10'h0, 0, 0, 0, 0);
    add(1, 16'h0659, 0, 0, 10'h0, 10'h0, S_ARMED, 0, 10'h0, 0, 0, 0, 0);
    add(1, 16'h0659, 0, 0, 10'h0, 10'h0, S_ARMED, 0, 10'h0, 0, 0, 0, 0);
    add(1, 16'h0700, 0, 0, 10'h0, 10'h0, S_RING,  1, 10'h0, 0, 0, 5, 0);
    add(1, 16'h0700, 0, 0, 10'h0, 10'h0, S_RING,  1, 10'h0, 0, 0, 5, 0);
    for (int k = 4; k >= 1; k--) add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_RING, 1, 10'h0, 0, 0, k, 0);
    add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_SNOOZE, 0, 10'h0, 0, 1, 3, 0);
    add(1, 16'h0700, 0, 0, 10'h0, 10'h0, S_SNOOZE, 0, 10'h0, 0, 1, 3, 0);
    for (int k = 2; k >= 1; k--) add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_SNOOZE, 0, 10'h0, 0, 1, k, 0);
    add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_RING, 1, 10'h0, 0, 1, 5, 0);
    for (int k = 4; k >= 1; k--) add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_RING, 1, 10'h0, 0, 1, k, 0);
    add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_SNOOZE, 0, 10'h0, 0, 2, 3, 0);
    for (int k = 2; k >= 1; k--) add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_SNOOZE, 0, 10'h0, 0, 2, k, 0);
    add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_RING, 1, 10'h0, 0, 2, 5, 0);
    for (int k = 4; k >= 0; k--) add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_RING, 1, 10'h0, 0, 2, k, 0);
    add(1, 16'h0700, 1, 0, 10'h0,   10'h0,   S_RING,  1, 10'h0,   0, 2, 0, 0);
    add(1, 16'h0700, 0, 1, 10'h008, 10'h0,   S_GAME,  1, 10'h008, 0, 2, 4, 0);
    add(1, 16'h0700, 0, 0, 10'h0,   10'h008, S_CLEAR, 1, 10'h0,   0, 2, 4, 0);
    add(1, 16'h0700, 0, 0, 10'h0,   10'h008, S_CLEAR, 1, 10'h0,   0, 2, 4, 0);
    add(1, 16'h0700, 0, 0, 10'h100, 10'h0,   S_GAME,  1, 10'h100, 1, 2, 4, 0);
    add(1, 16'h0700, 0, 0, 10'h0,   10'h100, S_CLEAR, 1, 10'h0,   1, 2, 4, 0);
    add(1, 16'h0700, 0, 0, 10'h001, 10'h0,   S_GAME,  1, 10'h001, 2, 2, 4, 0);
    add(1, 16'h0700, 0, 0, 10'h0,   10'h001, S_ARMED, 0, 10'h0,   0, 0, 0, 1);
    add(1, 16'h0700, 0, 0, 10'h0,   10'h001, S_ARMED, 0, 10'h0,   0, 0, 0, 0);
    add(1, 16'h0701, 0, 0, 10'h0,   10'h0,   S_ARMED, 0, 10'h0,   0, 0, 0, 0);
    add(1, 16'h0700, 0, 0, 10'h0,   10'h0,   S_RING,  1, 10'h0,   0, 0, 5, 0);
    add(1, 16'h0700, 0, 1, 10'h00C, 10'h0,   S_GAME,  1, 10'h001, 0, 0, 4, 0);
    for (int k = 3; k >= 1; k--) add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_GAME, 1, 10'h001, 0, 0, k, 0);
    add(1, 16'h0700, 1, 0, 10'h0,   10'h0,   S_RING,  1, 10'h0,   0, 0, 5, 0);
    add(1, 16'h0700, 0, 1, 10'h040, 10'h0,   S_GAME,  1, 10'h040, 0, 0, 4, 0);
    for (int k = 3; k >= 1; k--) add(1, 16'h0700, 1, 0, 10'h0, 10'h0, S_GAME, 1, 10'h040, 0, 0, k, 0);
    add(1, 16'h0700, 1, 0, 10'h0,   10'h040, S_CLEAR, 1, 10'h0,   0, 0, 1, 0);
    add(1, 16'h0700, 0, 0, 10'h200, 10'h0,   S_GAME,  1, 10'h200, 1, 0, 4, 0);
    add(1, 16'h0700, 0, 0, 10'h0,   10'h200, S_CLEAR, 1, 10'h0,   1, 0, 4, 0);
    add(0, 16'h0700, 0, 0, 10'h0,   10'h200, S_IDLE,  0, 10'h0,   0, 0, 0, 0);
    add(0, 16'h0700, 0, 0, 10'h0,   10'h0,   S_IDLE,  0, 10'h0,   0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      bus.enable = vecs[i].en; bus.current_time = vecs[i].ct; bus.tick = vecs[i].tk;
      bus.push_m = vecs[i].pm; bus.rand_hot = vecs[i].rh; bus.spdts = vecs[i].sw;
      step();
      check($sformatf("vec%0d", i), actual(), vecs[i].exp);
    end

    // ---------------- reset in the middle of a game ----------------
    bus.tick = 0; bus.push_m = 0; bus.spdts = '0; bus.rand_hot = '0;
    resetn = 1; bus.enable = 0; bus.current_time = 16'h0701;
    step();
    resetn = 0; bus.enable = 1;
    step();
    check("seq_armed", actual(), pack(S_ARMED, 0, 0, 0, 0, 0, 0));
    bus.current_time = 16'h0700;
    step();
    bus.push_m = 1; bus.rand_hot = 10'h010;
    step();
    check("seq_game", actual(), pack(S_GAME, 1, 10'h010, 0, 0, 4, 0));
    bus.push_m = 0; resetn = 1;
    step();
    check("reset_mid_game", actual(), pack(S_IDLE, 0, 0, 0, 0, 0, 0));
    resetn = 0;

    // ---------------- button and ring expiry in the same cycle ----------------
    bus.current_time = 16'h0701;
    step();
    bus.current_time = 16'h0700;
    step();
    check("ring_again", actual(), pack(S_RING, 1, 0, 0, 0, 5, 0));
    bus.tick = 1;
    for (int k = 0; k < 4; k++) step();
    check("ring_last_tick", actual(), pack(S_RING, 1, 0, 0, 0, 1, 0));
    bus.push_m = 1; bus.rand_hot = 10'h002;
    step();
    check("push_beats_expiry", actual(), pack(S_GAME, 1, 10'h002, 0, 0, 4, 0));
    bus.tick = 0; bus.push_m = 0;

    // ---------------- randomized run against the model ----------------
    resetn = 1;
    model_step(1);
    step();
    check("rand_reset", actual(), model_exp());
    resetn = 0;
    for (int i = 0; i < 4000; i++) begin
      bit rst;
      int r;
      rst = ($urandom_range(0, 499) == 0);
      resetn = rst;
      bus.enable = ($urandom_range(0, 63) != 0);
      bus.tick   = ($urandom_range(0, 2) == 0);
      bus.push_m = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0)
        bus.current_time = ($urandom_range(0, 1) == 1) ? 16'h0700 : 16'h0701;
      bus.rand_hot = ($urandom_range(0, 3) != 0) ? (10'h001 << $urandom_range(0, 9))
                                                 : 10'($urandom);
      r = $urandom_range(0, 3);
      bus.spdts = (r == 1) ? 10'h000 :
                  (r == 3) ? (10'h001 << $urandom_range(0, 9)) : m_target;
      model_step(rst);
      step();
      check($sformatf("rand%0d", i), actual(), model_exp());
    end
    resetn = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
